ftag_seq_feeder: RTL and testbench
==================================

Name: ftag_seq_feeder

Overview:
- Upstream stage of the GRU flavour-tagging network. Collects one jet's track features from a valid/ready stream into a ping-pong sequence buffer.
- Replays each jet to the GRU cell as exactly SEQ_LEN x_t vectors, one per step, tagged with first/last markers.
- Short jets are zero-padded. Over-long jets are truncated.
- While one jet plays out, the next jet loads.

Parameters:
- WIDTH, 4, feature word width (signed fixed point).
- X_SIZE, 6, features per track (GRU input dimension).
- SEQ_LEN, 15, GRU time steps per jet.
- STEP_CYCLES, 1, minimum cycles between successive x_t issues; must be >=1; matches GRU cell step latency.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  track word valid.
- in_ready  out  1  feeder can accept a track.
- in_data  in  WIDTH x [0:X_SIZE-1]  signed track features.
- in_last  in  1  marks the final track of a jet.
- x_t  out  WIDTH x [0:X_SIZE-1]  signed GRU input vector.
- x_valid  out  1  x_t valid this cycle.
- x_ready  in  1  GRU accepts x_t (tie high if unused).
- x_first  out  1  x_t is step 0 of a jet (GRU clears h).
- x_last  out  1  x_t is step SEQ_LEN-1 (GRU hidden state is final).
- trunc  out  1  one-cycle pulse: jet had more than SEQ_LEN tracks.

Behaviour:
- Reset (reset low, async) clears all state:
  - in_ready=0, x_valid=0, x_first=0, x_last=0, trunc=0, x_t=0.
  - Both banks marked empty.
  - First cycle after reset release: in_ready=1.
- Storage:
  - Two banks of SEQ_LEN x X_SIZE words.
  - Each bank has a track count cnt (0..SEQ_LEN) and a full flag.
- Write FSM states: W_FILL, W_DROP, W_WAIT.
  - W_FILL, in_ready=1. An accepted track (in_valid & in_ready) writes bank[wb][wr_idx] and increments wr_idx.
    - Accept with in_last: commit bank wb (full=1, cnt=wr_idx+1). Toggle wb. Next state W_FILL if the new wb is empty, else W_WAIT.
    - Accept at wr_idx==SEQ_LEN-1 without in_last: commit as above, then go to W_DROP.
  - W_DROP, in_ready=1. Tracks are discarded until an accepted word with in_last arrives.
    - On that word: trunc pulses for one cycle (next clock). Next state W_FILL or W_WAIT by the same rule as a commit.
  - W_WAIT, in_ready=0 until the target bank is freed. Reaches W_FILL the cycle after the free.
- Read FSM states: R_IDLE, R_PLAY, R_GAP.
  - R_IDLE: when bank rb is full, next cycle go to R_PLAY with rd_idx=0. Registered, so x_valid rises 1 cycle after commit.
  - R_PLAY, x_valid=1:
    - x_t = bank[rb][rd_idx] if rd_idx<cnt, else all zeros.
    - x_first=(rd_idx==0); x_last=(rd_idx==SEQ_LEN-1).
    - Outputs are held stable while x_ready=0.
    - On handshake: rd_idx++. Go to R_GAP for STEP_CYCLES-1 cycles with x_valid=0, or stay in R_PLAY if STEP_CYCLES==1.
  - Handshake at rd_idx==SEQ_LEN-1: clear full[rb], toggle rb. Go to R_IDLE, or straight to R_PLAY if the other bank is full, giving back-to-back jets with no bubble when STEP_CYCLES==1.
- Simultaneous commit by the writer and free by the reader on different banks in the same cycle: both take effect.
- A bank is never written while full.
- A jet of exactly SEQ_LEN tracks with in_last on the last track commits with no trunc.
- in_last on the first track gives cnt=1, then SEQ_LEN-1 zero vectors.
- Reset mid-playback aborts the jet. No x_last is emitted for it.
- Data passes through bit-exact; no arithmetic.

Optional Feature:
- Macro FTAG_FEED_REVERSE_EN.
- Defined: replay order is rd_idx = SEQ_LEN-1 down to 0, so padding zeros come first and the first stored track is the last step. x_first and x_last still mark the 1st and SEQ_LEN-th issued vector.
- Undefined: forward order as described in Behaviour.

Test Plan:
- 15 tracks streamed, in_last on the 15th, x_ready=1, STEP_CYCLES=1 -> x_valid high 15 consecutive cycles starting 1 cycle after the last accept; x_first on step 0, x_last on step 14; data matches input order; trunc never pulses.
- 3-track jet with features 1,2,3 -> steps 0-2 carry the tracks; steps 3-14 are all zeros; x_last asserted on step 14.
- 17-track jet -> first 15 tracks replayed; tracks 16 and 17 are dropped with in_ready held at 1; trunc pulses once after track 17.
- Three back-to-back 15-track jets with in_valid=1 continuously -> jet 2 loads during jet 1 playback; in_ready drops while both banks are full; 45 steps are emitted with no gaps between jets; order is preserved.
- STEP_CYCLES=3 with x_ready toggled 1/0 -> every x_valid is followed by 2 low cycles; x_t stays stable while stalled; no step is lost or duplicated.
- Reset asserted at step 7 of playback -> all outputs go to 0 asynchronously; after release the next jet starts at x_first with correct data. With FTAG_FEED_REVERSE_EN defined, repeat the 3-track test -> 12 zero steps, then tracks 3, 2, 1.

Source files
------------

// File: rtl/ftag_seq_feeder.sv
// ftag_seq_feeder
// Upstream stage of the GRU flavour-tagging network. Tracks of one jet are
// collected from a valid/ready stream into one bank of a ping-pong buffer.
// The other bank replays the previous jet as exactly SEQ_LEN x_t vectors.
// Short jets are zero-padded and over-long jets are truncated (trunc pulse).
// Optional feature: define FTAG_FEED_REVERSE_EN to replay each jet last step
// first, so the padding zeros lead and the first stored track comes last.
module ftag_seq_feeder #(
   parameter int WIDTH       = 4,
   parameter int X_SIZE      = 6,
   parameter int SEQ_LEN     = 15,
   parameter int STEP_CYCLES = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic signed [0:X_SIZE-1][WIDTH-1:0]  in_data,
   input  logic                                 in_last,
   output logic signed [0:X_SIZE-1][WIDTH-1:0]  x_t,
   output logic                                 x_valid,
   input  logic                                 x_ready,
   output logic                                 x_first,
   output logic                                 x_last,
   output logic                                 trunc
);

   localparam int CW = $clog2(SEQ_LEN + 1);
   localparam int GW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(SEQ_LEN - 1);

   localparam logic [1:0] W_FILL = 2'd0;
   localparam logic [1:0] W_DROP = 2'd1;
   localparam logic [1:0] W_WAIT = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_PLAY = 2'd1;
   localparam logic [1:0] R_GAP  = 2'd2;

   logic signed [0:X_SIZE-1][WIDTH-1:0] mem [0:1][0:SEQ_LEN-1];

   logic [1:0]    w_state;
   logic [1:0]    r_state;
   logic          wb;
   logic          rb;
   logic [CW-1:0] wr_idx;
   logic [CW-1:0] rd_idx;
   logic [CW-1:0] rd_addr;
   logic [CW-1:0] cnt [0:1];
   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic [GW-1:0] gap_cnt;

   logic accept;
   logic commit;
   logic step_hs;
   logic free_bank;

   assign in_ready  = (w_state == W_FILL) || (w_state == W_DROP);
   assign accept    = in_valid && in_ready;
   assign commit    = (w_state == W_FILL) && accept && (in_last || (wr_idx == LAST_IDX));
   assign x_valid   = (r_state == R_PLAY);
   assign step_hs   = x_valid && x_ready;
   assign free_bank = step_hs && (rd_idx == LAST_IDX);
   assign x_first   = x_valid && (rd_idx == '0);
   assign x_last    = x_valid && (rd_idx == LAST_IDX);

   // Bank occupancy as it will be after this edge; lets a commit and a free on opposite banks land together
   always_comb begin
      full_nxt = full;
      if (free_bank) begin
         full_nxt[rb] = 1'b0;
      end
      if (commit) begin
         full_nxt[wb] = 1'b1;
      end
   end

   // Map the step number onto the stored slot, last slot first when replay is reversed
   always_comb begin
`ifdef FTAG_FEED_REVERSE_EN
      rd_addr = LAST_IDX - rd_idx;
`else
      rd_addr = rd_idx;
`endif
   end

   // Present the stored track for this step, or zeros for padding steps and whenever idle
   always_comb begin
      x_t = '0;
      if (x_valid && (rd_addr < cnt[rb])) begin
         x_t = mem[rb][rd_addr];
      end
   end

   // Track storage; only the filling bank is written and it is never full while filling
   always_ff @(posedge clk) begin
      if ((w_state == W_FILL) && accept) begin
         mem[wb][wr_idx] <= in_data;
      end
   end

   // Bank full flags and committed track counts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full   <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         full <= full_nxt;
         if (commit) begin
            cnt[wb] <= wr_idx + 1'b1;
         end
      end
   end

   // Write side: fill a bank, drop overflow tracks, or wait for the next bank to drain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state <= W_WAIT;
         wb      <= 1'b0;
         wr_idx  <= '0;
         trunc   <= 1'b0;
      end else begin
         trunc <= 1'b0;
         case (w_state)
            W_FILL: begin
               if (accept) begin
                  if (commit) begin
                     wr_idx <= '0;
                     wb     <= ~wb;
                     if (!in_last) begin
                        w_state <= W_DROP;
                     end else if (full_nxt[~wb]) begin
                        w_state <= W_WAIT;
                     end else begin
                        w_state <= W_FILL;
                     end
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end
            end
            W_DROP: begin
               if (accept && in_last) begin
                  trunc   <= 1'b1;
                  w_state <= full_nxt[wb] ? W_WAIT : W_FILL;
               end
            end
            W_WAIT: begin
               if (!full_nxt[wb]) begin
                  w_state <= W_FILL;
               end
            end
            default: begin
               w_state <= W_WAIT;
            end
         endcase
      end
   end

   // Read side: replay SEQ_LEN steps per jet, spaced by STEP_CYCLES, chaining jets without a bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= R_IDLE;
         rb      <= 1'b0;
         rd_idx  <= '0;
         gap_cnt <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (full[rb]) begin
                  r_state <= R_PLAY;
                  rd_idx  <= '0;
               end
            end
            R_PLAY: begin
               if (x_ready) begin
                  if (rd_idx == LAST_IDX) begin
                     rb     <= ~rb;
                     rd_idx <= '0;
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
                  if (STEP_CYCLES > 1) begin
                     r_state <= R_GAP;
                     gap_cnt <= GW'(STEP_CYCLES - 1);
                  end else if (rd_idx == LAST_IDX) begin
                     r_state <= full_nxt[~rb] ? R_PLAY : R_IDLE;
                  end
               end
            end
            R_GAP: begin
               if (gap_cnt <= GW'(1)) begin
                  if (rd_idx != '0) begin
                     r_state <= R_PLAY;
                  end else begin
                     r_state <= full[rb] ? R_PLAY : R_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= R_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ftag_seq_feeder.sv
// tb_ftag_seq_feeder
// Scoreboard bench for ftag_seq_feeder. Expected x_t steps are queued when a
// jet is driven and popped as the feeder emits them. A second instance runs
// with STEP_CYCLES=3 and a toggling x_ready. Honours FTAG_FEED_REVERSE_EN.
module tb_ftag_seq_feeder;

   localparam int WIDTH   = 4;
   localparam int X_SIZE  = 6;
   localparam int SEQ_LEN = 15;
   localparam int DW      = WIDTH * X_SIZE;
`ifdef FTAG_FEED_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic          first;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   logic          in_valid, in_ready, in_last, x_valid, x_ready, x_first, x_last, trunc;
   logic [DW-1:0] in_data, x_t;

   logic          in_valid3, in_ready3, in_last3, x_valid3, x_ready3, x_first3, x_last3, trunc3;
   logic [DW-1:0] in_data3, x_t3;

   exp_t q1[$];
   exp_t q3[$];
   exp_t e1;
   exp_t e3;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int steps1       = 0;
   int steps3       = 0;
   int trunc_cnt    = 0;
   int hs_gaps      = 0;
   int last_hs_cyc  = -1;
   int gap_left     = 0;
   bit stalled3     = 1'b0;
   logic [DW+1:0] held3;

   always #5 clk = ~clk;

   ftag_seq_feeder #(.WIDTH(WIDTH), .X_SIZE(X_SIZE), .SEQ_LEN(SEQ_LEN), .STEP_CYCLES(1)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .x_t(x_t), .x_valid(x_valid), .x_ready(x_ready), .x_first(x_first), .x_last(x_last),
      .trunc(trunc)
   );

   ftag_seq_feeder #(.WIDTH(WIDTH), .X_SIZE(X_SIZE), .SEQ_LEN(SEQ_LEN), .STEP_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_last(in_last3),
      .x_t(x_t3), .x_valid(x_valid3), .x_ready(x_ready3), .x_first(x_first3), .x_last(x_last3),
      .trunc(trunc3)
   );

   // Track word for jet/track; jet 0 carries feature value t+1 in every lane
   function automatic logic [DW-1:0] trk(input int jet, input int t);
      logic [WIDTH-1:0] f;
      if (jet == 0) begin
         f = WIDTH'(t + 1);
         return {X_SIZE{f}};
      end
      return DW'(jet * 945 + t * 471 + 370625);
   endfunction

   // Queue the SEQ_LEN steps a jet of n tracks must produce
   task automatic push_jet(input bit sel, input int jet, input int n);
      exp_t e;
      int   addr;
      for (int k = 0; k < SEQ_LEN; k++) begin
         addr    = REV ? (SEQ_LEN - 1 - k) : k;
         e.data  = (addr < n) ? trk(jet, addr) : '0;
         e.first = (k == 0);
         e.last  = (k == SEQ_LEN - 1);
         if (sel) q3.push_back(e);
         else     q1.push_back(e);
      end
   endtask

   // Stream one jet into the selected instance; counts cycles spent with in_ready low
   task automatic drive_jet(input bit sel, input int jet, input int n, output int stalls);
      stalls = 0;
      for (int t = 0; t < n; t++) begin
         int waited;
         bit ok;
         if (sel) begin
            in_valid3 = 1'b1; in_data3 = trk(jet, t); in_last3 = (t == n - 1);
         end else begin
            in_valid  = 1'b1; in_data  = trk(jet, t); in_last  = (t == n - 1);
         end
         waited = 0;
         ok     = 1'b0;
         while (!ok && waited < 200) begin
            @(negedge clk);
            ok = sel ? (in_ready3 === 1'b1) : (in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (!ok) begin
               stalls++;
               waited++;
            end
         end
         if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drive_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
            break;
         end
      end
      if (sel) begin
         in_valid3 = 1'b0; in_last3 = 1'b0;
      end else begin
         in_valid  = 1'b0; in_last  = 1'b0;
      end
   endtask

   // Bounded wait for a scoreboard queue to empty
   task automatic wait_empty(input bit sel, input int budget);
      int c;
      c = 0;
      while (((sel ? q3.size() : q1.size()) != 0) && c < budget) begin
         @(posedge clk);
         c++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard for the STEP_CYCLES=1 instance
   always @(negedge clk) begin
      if (trunc === 1'b1) trunc_cnt++;
      if (x_valid === 1'b1 && x_ready === 1'b1) begin
         tests_run++;
         if (q1.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_step: got x_t=%h first=%b last=%b, required no step", x_t, x_first, x_last);
         end else begin
            e1 = q1.pop_front();
            if (x_t !== e1.data || x_first !== e1.first || x_last !== e1.last) begin
               tests_failed++;
               $display("[TB] FAIL step_data: got x_t=%h first=%b last=%b, required x_t=%h first=%b last=%b",
                        x_t, x_first, x_last, e1.data, e1.first, e1.last);
            end
         end
         steps1++;
         if (last_hs_cyc >= 0 && (cyc - last_hs_cyc) != 1) hs_gaps++;
         last_hs_cyc = cyc;
      end
   end

   // Scoreboard for the STEP_CYCLES=3 instance: spacing, stall stability and data
   always @(negedge clk) begin
      if (gap_left > 0) begin
         tests_run++;
         if (x_valid3 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL step_gap: got x_valid=%b in gap, required 0", x_valid3);
         end
         gap_left--;
      end else if (x_valid3 === 1'b1) begin
         if (stalled3) begin
            tests_run++;
            if ({x_t3, x_first3, x_last3} !== held3) begin
               tests_failed++;
               $display("[TB] FAIL stall_hold: got %h, required %h", {x_t3, x_first3, x_last3}, held3);
            end
         end
         if (x_ready3 === 1'b1) begin
            tests_run++;
            steps3++;
            stalled3 = 1'b0;
            gap_left = 2;
            if (q3.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL unexpected_step3: got x_t=%h, required no step", x_t3);
            end else begin
               e3 = q3.pop_front();
               if (x_t3 !== e3.data || x_first3 !== e3.first || x_last3 !== e3.last) begin
                  tests_failed++;
                  $display("[TB] FAIL step3_data: got x_t=%h first=%b last=%b, required x_t=%h first=%b last=%b",
                           x_t3, x_first3, x_last3, e3.data, e3.first, e3.last);
               end
            end
         end else begin
            stalled3 = 1'b1;
            held3    = {x_t3, x_first3, x_last3};
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0;
      #23;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_in_ready: got %b, required 0", in_ready); end
      tests_run++;
      if ({x_valid, x_first, x_last, trunc} !== 4'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_flags: got valid/first/last/trunc=%b, required 0000", {x_valid, x_first, x_last, trunc});
      end
      tests_run++;
      if (x_t !== '0) begin tests_failed++; $display("[TB] FAIL rst_x_t: got %h, required 0", x_t); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_release_ready: got %b, required 1", in_ready); end
      tests_run++;
      if (x_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_release_valid: got %b, required 0", x_valid); end
   endtask

   task automatic test_full_jet();
      int st, t0, s0, run;
      t0 = trunc_cnt;
      s0 = steps1;
      push_jet(1'b0, 1, 15);
      drive_jet(1'b0, 1, 15, st);
      @(negedge clk);
      tests_run++;
      if (x_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_latency: got x_valid=%b one edge after commit, required 0", x_valid); end
      run = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (x_valid === 1'b1) run++;
      end
      tests_run++;
      if (run != 15) begin tests_failed++; $display("[TB] FAIL full_run: got %0d valid cycles, required 15", run); end
      @(negedge clk);
      tests_run++;
      if (x_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_end: got x_valid=%b, required 0", x_valid); end
      wait_empty(1'b0, 100);
      tests_run++;
      if (q1.size() != 0) begin tests_failed++; $display("[TB] FAIL full_pending: got %0d, required 0", q1.size()); q1.delete(); end
      tests_run++;
      if (trunc_cnt - t0 != 0) begin tests_failed++; $display("[TB] FAIL full_trunc: got %0d pulses, required 0", trunc_cnt - t0); end
      tests_run++;
      if (steps1 - s0 != 15) begin tests_failed++; $display("[TB] FAIL full_steps: got %0d, required 15", steps1 - s0); end
   endtask

   task automatic test_short_jet();
      int st, t0, s0;
      t0 = trunc_cnt;
      s0 = steps1;
      push_jet(1'b0, 0, 3);
      drive_jet(1'b0, 0, 3, st);
      wait_empty(1'b0, 100);
      tests_run++;
      if (q1.size() != 0) begin tests_failed++; $display("[TB] FAIL short_pending: got %0d, required 0", q1.size()); q1.delete(); end
      tests_run++;
      if (steps1 - s0 != 15) begin tests_failed++; $display("[TB] FAIL short_steps: got %0d, required 15", steps1 - s0); end
      tests_run++;
      if (trunc_cnt - t0 != 0) begin tests_failed++; $display("[TB] FAIL short_trunc: got %0d pulses, required 0", trunc_cnt - t0); end
   endtask

   task automatic test_truncate();
      int st, t0, s0;
      t0 = trunc_cnt;
      s0 = steps1;
      push_jet(1'b0, 2, 17);
      drive_jet(1'b0, 2, 17, st);
      tests_run++;
      if (st != 0) begin tests_failed++; $display("[TB] FAIL trunc_ready: got %0d stall cycles, required 0", st); end
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (trunc_cnt - t0 != 1) begin tests_failed++; $display("[TB] FAIL trunc_pulse: got %0d pulse cycles, required 1", trunc_cnt - t0); end
      wait_empty(1'b0, 100);
      tests_run++;
      if (q1.size() != 0) begin tests_failed++; $display("[TB] FAIL trunc_pending: got %0d, required 0", q1.size()); q1.delete(); end
      tests_run++;
      if (steps1 - s0 != 15) begin tests_failed++; $display("[TB] FAIL trunc_steps: got %0d, required 15", steps1 - s0); end
   endtask

   task automatic test_back_to_back();
      int st, stalls, s0;
      s0          = steps1;
      hs_gaps     = 0;
      last_hs_cyc = -1;
      stalls      = 0;
      for (int j = 3; j <= 5; j++) push_jet(1'b0, j, 15);
      for (int j = 3; j <= 5; j++) begin
         drive_jet(1'b0, j, 15, st);
         stalls += st;
      end
      wait_empty(1'b0, 200);
      tests_run++;
      if (q1.size() != 0) begin tests_failed++; $display("[TB] FAIL b2b_pending: got %0d, required 0", q1.size()); q1.delete(); end
      tests_run++;
      if (steps1 - s0 != 45) begin tests_failed++; $display("[TB] FAIL b2b_steps: got %0d, required 45", steps1 - s0); end
      tests_run++;
      if (hs_gaps != 0) begin tests_failed++; $display("[TB] FAIL b2b_gaps: got %0d gaps, required 0", hs_gaps); end
      tests_run++;
      if (stalls == 0) begin tests_failed++; $display("[TB] FAIL b2b_backpressure: got %0d stall cycles, required >0", stalls); end
   endtask

   task automatic test_step_gap();
      int st;
      bit done;
      done = 1'b0;
      fork
         begin
            push_jet(1'b1, 8, 15);
            push_jet(1'b1, 9, 4);
            drive_jet(1'b1, 8, 15, st);
            drive_jet(1'b1, 9, 4, st);
            wait_empty(1'b1, 600);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               x_ready3 = ~x_ready3;
            end
         end
      join
      x_ready3 = 1'b1;
      tests_run++;
      if (q3.size() != 0) begin tests_failed++; $display("[TB] FAIL gap_pending: got %0d, required 0", q3.size()); q3.delete(); end
      tests_run++;
      if (steps3 != 30) begin tests_failed++; $display("[TB] FAIL gap_steps: got %0d, required 30", steps3); end
   endtask

   task automatic test_reset_mid();
      int st, s0, c;
      s0 = steps1;
      push_jet(1'b0, 6, 15);
      drive_jet(1'b0, 6, 15, st);
      c = 0;
      while ((steps1 - s0) < 7 && c < 100) begin
         @(posedge clk);
         c++;
      end
      #3;
      reset = 1'b0;
      #1;
      tests_run++;
      if ({x_valid, x_first, x_last, trunc, in_ready} !== 5'b0) begin
         tests_failed++;
         $display("[TB] FAIL mid_rst_flags: got valid/first/last/trunc/ready=%b, required 00000",
                  {x_valid, x_first, x_last, trunc, in_ready});
      end
      tests_run++;
      if (x_t !== '0) begin tests_failed++; $display("[TB] FAIL mid_rst_x_t: got %h, required 0", x_t); end
      q1.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      s0 = steps1;
      repeat (5) @(posedge clk);
      #1;
      tests_run++;
      if (steps1 != s0) begin tests_failed++; $display("[TB] FAIL mid_abort: got %0d steps after release, required 0", steps1 - s0); end
      push_jet(1'b0, 7, 15);
      drive_jet(1'b0, 7, 15, st);
      wait_empty(1'b0, 100);
      tests_run++;
      if (q1.size() != 0) begin tests_failed++; $display("[TB] FAIL mid_pending: got %0d, required 0", q1.size()); q1.delete(); end
      tests_run++;
      if (steps1 - s0 != 15) begin tests_failed++; $display("[TB] FAIL mid_steps: got %0d, required 15", steps1 - s0); end
   endtask

   // Run every scenario in order, then report
   initial begin
      in_valid  = 1'b0; in_last  = 1'b0; in_data  = '0; x_ready  = 1'b1;
      in_valid3 = 1'b0; in_last3 = 1'b0; in_data3 = '0; x_ready3 = 1'b1;
      test_reset();
      test_full_jet();
      test_short_jet();
      test_truncate();
      test_back_to_back();
      test_step_gap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
